run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Synthesizable run controller for the CPU test harness. Replaces hard-coded initial-block reset pulses and fixed `$finish` delays.
- Sequences an instruction-memory load handshake, then releases staggered resets to NUM_DOMAINS cores.
- Counts run cycles and ends the run on a core halt request or a cycle timeout.
- Sits between the bench (or an FPGA debug bridge) and the top-level core instances.

Parameters:
- RST_HOLD_CYCLES, 1: cycles core resets stay asserted after load completes, before domain 0 is released.
- TIMEOUT_CYCLES, 50: run-cycle limit; 0 disables the timeout.
- NUM_DOMAINS, 1: number of core reset outputs, 1..8.
- CNT_W, 16: width of the cycle and retire counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins (or restarts) a run.
- load_req  out  1  request to the imem loader to initialise memory.
- load_ack  in  1  loader done; sampled only while load_req=1.
- halt_req  in  NUM_DOMAINS  per-core halt indication (e.g. ecall/halt retire).
- core_reset  out  NUM_DOMAINS  active-high reset to each core domain.
- running  out  1  high in the RUN state.
- done  out  1  high in the DONE state.
- halted  out  1  sticky: run ended by a halt request.
- timeout  out  1  sticky: run ended by the cycle limit.
- cycle_cnt  out  CNT_W  RUN-cycle count; holds its value in DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, load_req=0, core_reset=all 1s, running=0, done=0, halted=0, timeout=0, cycle_cnt=0, hold counter=0.
- All outputs are registered; no combinational input-to-output paths.
- FSM states: IDLE, LOAD, HOLD, RUN, DONE.
- IDLE:
  - core_reset all 1s.
  - start=1 -> LOAD next cycle.
- LOAD:
  - load_req=1.
  - load_ack=1 -> HOLD next cycle and load_req=0 in that cycle.
  - No timeout in LOAD; it waits for load_ack indefinitely.
- HOLD:
  - hold counter h starts at 0 and increments every cycle.
  - core_reset[i] deasserts on the cycle after h == RST_HOLD_CYCLES-1+i. Domain i is therefore released exactly i cycles after domain 0.
  - When h == RST_HOLD_CYCLES+NUM_DOMAINS-2 -> RUN. With NUM_DOMAINS=1, that is when h == RST_HOLD_CYCLES-1.
  - RST_HOLD_CYCLES=0 is treated as 1.
- RUN:
  - running=1.
  - cycle_cnt increments every cycle, starting at 0 in the first RUN cycle, and saturates at all 1s.
  - Any bit of halt_req=1 -> DONE next cycle with halted=1.
  - TIMEOUT_CYCLES!=0 and cycle_cnt == TIMEOUT_CYCLES-1 -> DONE with timeout=1.
  - Halt and timeout in the same cycle: halted=1, timeout=0 (halt wins).
- DONE:
  - done=1, running=0, core_reset re-asserted to all 1s.
  - cycle_cnt, halted and timeout hold their values.
- start handling:
  - start in DONE -> LOAD, clearing cycle_cnt, halted and timeout in the same edge.
  - start in LOAD, HOLD or RUN is ignored.
- halt_req is ignored outside RUN.
- load_ack is ignored outside LOAD.
- Reset asserted mid-run returns to the reset values immediately; it does not wait for a clock edge.

Optional Feature:
- Macro RUN_CTRL_RETIRE_EN.
- Defined:
  - Adds input retire (NUM_DOMAINS bits, per-core instruction-retire pulses).
  - Adds output retire_cnt (CNT_W), which sums popcount(retire) each RUN cycle.
  - retire_cnt saturates at all 1s, is cleared on start and on reset, and holds its value in DONE.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Reset and load: reset=0 for 2 cycles, then release; start pulse; load_ack after 3 cycles -> load_req high for exactly 3 cycles, then HOLD; with RST_HOLD_CYCLES=1, core_reset[0] falls one cycle after HOLD entry.
- Staggered release: NUM_DOMAINS=3, RST_HOLD_CYCLES=2 -> core_reset bits fall at HOLD cycles 2, 3 and 4; running rises with the last release.
- Halt: halt_req[1] pulsed on RUN cycle 10 -> done=1, halted=1, timeout=0, cycle_cnt=10 held, core_reset=3'b111.
- Timeout and collision: TIMEOUT_CYCLES=50, no halt -> timeout=1 with cycle_cnt=49; separately, halt on cycle 49 -> halted=1, timeout=0.
- Restart and async reset: start in DONE -> flags and counter cleared, LOAD re-entered; start during RUN has no effect; reset=0 mid-RUN -> outputs at reset values before the next clk edge.
- RUN_CTRL_RETIRE_EN: NUM_DOMAINS=2, retire=2'b11 for 5 cycles then 2'b01 for 3 cycles -> retire_cnt=13; CNT_W=4 saturates at 15.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: sequences imem load, staggered core reset release, run-cycle counting and halt/timeout end of run
// Ports: clk; reset (async, active-low); start pulse; load_req/load_ack loader handshake;
//   halt_req[NUM_DOMAINS] per-core halt; core_reset[NUM_DOMAINS] active-high core resets;
//   running/done state flags; halted/timeout sticky end cause; cycle_cnt run-cycle count.
// Optional: define RUN_CTRL_RETIRE_EN to add retire[NUM_DOMAINS] input and retire_cnt output.
module run_ctrl #(
    parameter int RST_HOLD_CYCLES = 1,
    parameter int TIMEOUT_CYCLES  = 50,
    parameter int NUM_DOMAINS     = 1,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   load_req,
    input  logic                   load_ack,
    input  logic [NUM_DOMAINS-1:0] halt_req,
    output logic [NUM_DOMAINS-1:0] core_reset,
    output logic                   running,
    output logic                   done,
    output logic                   halted,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycle_cnt
`ifdef RUN_CTRL_RETIRE_EN
    ,
    input  logic [NUM_DOMAINS-1:0] retire,
    output logic [CNT_W-1:0]       retire_cnt
`endif
);
    localparam int RH = (RST_HOLD_CYCLES < 1) ? 1 : RST_HOLD_CYCLES;
    localparam int HW = $clog2(RH + NUM_DOMAINS + 1);
    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE} state_t;
    state_t                 state_q, state_d;
    logic [HW-1:0]          h_q, h_d;
    logic [NUM_DOMAINS-1:0] core_reset_q, core_reset_d;
    logic                   load_req_q, load_req_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic                   halted_q, halted_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
    logic                   hit_halt, hit_to;
    always_comb begin
        hit_halt = |halt_req;
        hit_to   = (TIMEOUT_CYCLES != 0) && (32'(cycle_cnt_q) == 32'(TIMEOUT_CYCLES - 1));
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = load_ack ? HOLD : LOAD;
            HOLD:    state_d = (h_q == HW'(RH + NUM_DOMAINS - 2)) ? RUN : HOLD;
            RUN:     state_d = (hit_halt || hit_to) ? DONE : RUN;
            DONE:    state_d = start ? LOAD : DONE;
            default: state_d = IDLE;
        endcase
        h_d = (state_q == HOLD) ? h_q + 1'b1 : '0;
        // released domains stay released until the run ends; domain i drops when h reaches RH-1+i
        core_reset_d = '1;
        if (state_d == HOLD || state_d == RUN)
            for (int i = 0; i < NUM_DOMAINS; i++)
                core_reset_d[i] = core_reset_q[i] & ~(state_q == HOLD && h_q == HW'(RH - 1 + i));
        load_req_d  = state_d == LOAD;
        running_d   = state_d == RUN;
        done_d      = state_d == DONE;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        cycle_cnt_d = cycle_cnt_q;
        if (state_d == LOAD) begin
            halted_d    = 1'b0;
            timeout_d   = 1'b0;
            cycle_cnt_d = '0;
        end else if (state_q == RUN && state_d == DONE) begin
            halted_d  = hit_halt;
            timeout_d = ~hit_halt;
        end else if (state_q == RUN) begin
            cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            h_q          <= '0;
            core_reset_q <= '1;
            load_req_q   <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            core_reset_q <= core_reset_d;
            load_req_q   <= load_req_d;
            running_q    <= running_d;
            done_q       <= done_d;
            halted_q     <= halted_d;
            timeout_q    <= timeout_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end
    assign load_req   = load_req_q;
    assign core_reset = core_reset_q;
    assign running    = running_q;
    assign done       = done_q;
    assign halted     = halted_q;
    assign timeout    = timeout_q;
    assign cycle_cnt  = cycle_cnt_q;
`ifdef RUN_CTRL_RETIRE_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_W:0]   retire_sum;
    always_comb begin
        retire_sum   = {1'b0, retire_cnt_q} + (CNT_W + 1)'($countones(retire));
        retire_cnt_d = (state_d == LOAD) ? '0 :
                       (state_q == RUN)  ? (retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0]) :
                                           retire_cnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retire_cnt_q <= '0;
        else        retire_cnt_q <= retire_cnt_d;
    end
    assign retire_cnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized run sequences against a timeline model derived from the run-controller rules
module tb_run_ctrl;
    localparam int N = 3, R = 2, T = 50;
    logic        clk = 0, reset = 0;
    logic        start = 0, load_ack = 0;
    logic [2:0]  halt_req = 0;
    logic        load_req, running, done, halted, timeout;
    logic [2:0]  core_reset;
    logic [15:0] cycle_cnt;
    logic        start_b = 0, ack_b = 0, halt_b = 0;
    logic        load_req_b, running_b, done_b, halted_b, timeout_b, core_reset_b;
    logic [3:0]  cycle_cnt_b;
`ifdef RUN_CTRL_RETIRE_EN
    logic [2:0]  retire = 0;
    logic [15:0] retire_cnt;
    logic [3:0]  retire_cnt_b;
    int          exp_ret = 0;
`endif
    int n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    run_ctrl #(.RST_HOLD_CYCLES(R), .TIMEOUT_CYCLES(T), .NUM_DOMAINS(N), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .start(start), .load_req(load_req), .load_ack(load_ack),
        .halt_req(halt_req), .core_reset(core_reset), .running(running), .done(done),
        .halted(halted), .timeout(timeout), .cycle_cnt(cycle_cnt)
`ifdef RUN_CTRL_RETIRE_EN
        , .retire(retire), .retire_cnt(retire_cnt)
`endif
    );
    run_ctrl #(.RST_HOLD_CYCLES(0), .TIMEOUT_CYCLES(0), .NUM_DOMAINS(1), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .load_req(load_req_b), .load_ack(ack_b),
        .halt_req(halt_b), .core_reset(core_reset_b), .running(running_b), .done(done_b),
        .halted(halted_b), .timeout(timeout_b), .cycle_cnt(cycle_cnt_b)
`ifdef RUN_CTRL_RETIRE_EN
        , .retire(1'b1), .retire_cnt(retire_cnt_b)
`endif
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic check_idle_a(input string tag);
        check(tag, 32'({load_req, running, done, halted, timeout, core_reset}), 32'(8'b00000111));
        check({tag, "_cnt"}, 32'(cycle_cnt), 0);
    endtask
    task automatic run_a(input int lw, input int halt_at);
        logic hl;
        int   end_c;
        hl    = (halt_at >= 0 && halt_at < T);
        end_c = hl ? halt_at : T - 1;
        start = 1;
        @(negedge clk);
        start = 0;
        check("load_entry", 32'({load_req, done, halted, timeout, core_reset}), 32'(7'b1000111));
        check("cnt_clear", 32'(cycle_cnt), 0);
`ifdef RUN_CTRL_RETIRE_EN
        check("ret_clear", 32'(retire_cnt), 0);
        exp_ret = 0;
`endif
        for (int j = 1; j <= lw; j++) begin
            check("load_req", 32'({load_req, running}), 32'(2'b10));
            load_ack = (j == lw);
            start    = 1'($urandom_range(0, 1));
            halt_req = 3'($urandom);
            @(negedge clk);
        end
        load_ack = 0;
        for (int k = 0; k <= R + N - 2; k++) begin
            logic [2:0] e;
            for (int i = 0; i < N; i++) e[i] = !(k >= R + i);
            check("hold_rst", 32'(core_reset), 32'(e));
            check("hold_flags", 32'({load_req, running, done}), 0);
            start    = 1'($urandom_range(0, 1));
            halt_req = 3'($urandom);
            load_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        for (int c = 0; c <= end_c; c++) begin
            check("run_state", 32'({running, done, load_req, core_reset}), 32'(6'b100000));
            check("run_cnt", 32'(cycle_cnt), c);
`ifdef RUN_CTRL_RETIRE_EN
            check("run_ret", 32'(retire_cnt), exp_ret);
            retire  = 3'($urandom);
            exp_ret += $countones(retire);
`endif
            halt_req = (hl && c == end_c) ? 3'($urandom_range(1, 7)) : 3'b000;
            start    = 1'($urandom_range(0, 1));
            load_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 0;
        for (int d = 0; d < 3; d++) begin
            check("done_flags", 32'({done, running, load_req, halted, timeout, core_reset}),
                  32'({3'b100, hl, !hl, 3'b111}));
            check("done_cnt", 32'(cycle_cnt), end_c);
`ifdef RUN_CTRL_RETIRE_EN
            check("done_ret", 32'(retire_cnt), exp_ret);
            retire = 3'($urandom);
`endif
            halt_req = 3'($urandom);
            load_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        halt_req = 0;
        load_ack = 0;
    endtask
    initial begin
        @(negedge clk);
        check_idle_a("rst_a");
        check("rst_b", 32'({load_req_b, running_b, done_b, halted_b, timeout_b, core_reset_b, cycle_cnt_b}),
              32'(10'b0000010000));
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_idle_a("idle_a");
        // second instance: zero hold treated as one, timeout disabled, 4-bit counter saturates
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        check("b_load", 32'({load_req_b, core_reset_b}), 32'(2'b11));
        ack_b = 1;
        @(negedge clk);
        ack_b = 0;
        check("b_hold", 32'({load_req_b, core_reset_b, running_b}), 32'(3'b010));
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            check("b_run", 32'({running_b, core_reset_b, done_b}), 32'(3'b100));
            check("b_cnt", 32'(cycle_cnt_b), (c < 15) ? c : 15);
`ifdef RUN_CTRL_RETIRE_EN
            check("b_ret", 32'(retire_cnt_b), (c < 15) ? c : 15);
`endif
            @(negedge clk);
        end
        halt_b = 1;
        @(negedge clk);
        halt_b = 0;
        check("b_done", 32'({done_b, running_b, halted_b, timeout_b, core_reset_b, cycle_cnt_b}),
              32'({5'b10101, 4'd15}));
        run_a(3, 10);
        run_a(1, -1);
        run_a(2, 49);
        run_a(1, 0);
        repeat (6) run_a(int'($urandom_range(1, 4)), int'($urandom_range(0, 60)));
        // asynchronous reset in the middle of a run
        start = 1;
        @(negedge clk);
        start = 0;
        load_ack = 1;
        @(negedge clk);
        load_ack = 0;
        repeat (R + N + 4) @(negedge clk);
        check("pre_rst_run", 32'(running), 1);
        #2 reset = 0;
        #1 check_idle_a("async_rst");
`ifdef RUN_CTRL_RETIRE_EN
        check("async_rst_ret", 32'(retire_cnt), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_idle_a("post_rst_idle");
        run_a(2, int'($urandom_range(0, 60)));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
